// File: rtl/face_grid_editor.sv
// face_grid_editor
// Editable GRID_N x GRID_N grid of coloured squares with a cursor, plus a
// per-pixel renderer that reports whether the current pixel lies in a square
// and which colour to draw there.
//
// Optional feature macro: GRID_CURSOR_BLINK_EN
//   When defined, the cursor border blinks with a period of 2*BLINK_CYCLES
//   clocks. The blink restarts at the lit phase on every cursor move.
//   When undefined, the cursor border is steady 3'b111 and no counter exists.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   isX, isY          : current pixel coordinate
//   X_pos, Y_pos      : grid top-left origin
//   btn_up/down/left/right/cycle : level buttons, acted on at their rising edge
//   isSet, colour     : registered pixel result (one clk latency)
//   cursor_row/col    : registered cursor position
//   state_flat        : registered square colours, square (r,c) at [3*(r*GRID_N+c) +: 3]
module face_grid_editor #(
  parameter int unsigned GRID_N       = 3,
  parameter int unsigned SQ_LEN       = 26,
  parameter int unsigned BORDER       = 3,
  parameter int unsigned GAP          = 2,
  parameter logic [2:0]  INIT_COLOUR  = 3'b001,
  parameter int unsigned BLINK_CYCLES = 12500000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8:0]                    isX,
  input  logic [7:0]                    isY,
  input  logic [8:0]                    X_pos,
  input  logic [7:0]                    Y_pos,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          btn_left,
  input  logic                          btn_right,
  input  logic                          btn_cycle,
  output logic                          isSet,
  output logic [2:0]                    colour,
  output logic [$clog2(GRID_N)-1:0]     cursor_row,
  output logic [$clog2(GRID_N)-1:0]     cursor_col,
  output logic [3*GRID_N*GRID_N-1:0]    state_flat
);

  localparam int unsigned CW    = $clog2(GRID_N);
  localparam int unsigned NSQ   = GRID_N * GRID_N;
  localparam int unsigned SW    = 3 * NSQ;
  localparam int unsigned PITCH = SQ_LEN + GAP;

  // Button bit order: {up, down, left, right, cycle}
  localparam int unsigned B_UP    = 4;
  localparam int unsigned B_DOWN  = 3;
  localparam int unsigned B_LEFT  = 2;
  localparam int unsigned B_RIGHT = 1;
  localparam int unsigned B_CYC   = 0;

  logic [SW-1:0] r_state;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [4:0]    r_btn_q;
  logic          r_arm;
  logic          r_isSet;
  logic [2:0]    r_colour;

  logic [4:0]    w_btn;
  logic [4:0]    w_edge;
  logic [CW-1:0] w_row_nxt;
  logic [CW-1:0] w_col_nxt;
  int unsigned   w_cur_idx;
  logic [2:0]    w_cur_colour;
  logic [2:0]    w_cyc_colour;
  logic          w_blink_phase;
  logic [2:0]    w_cursor_border;
  logic          w_isSet;
  logic [2:0]    w_colour;

  assign w_btn = {btn_up, btn_down, btn_left, btn_right, btn_cycle};

  // r_arm is low for the first cycle after reset so that buttons held across
  // reset release are absorbed into the history instead of firing.
  assign w_edge = w_btn & ~r_btn_q & {5{r_arm}};

  // Square under the cursor and its successor colour
  always_comb begin
    w_cur_idx    = 32'(r_row) * GRID_N + 32'(r_col);
    w_cur_colour = 3'b000;
    for (int i = 0; i < int'(NSQ); i++) begin
      if (w_cur_idx == 32'(i)) w_cur_colour = r_state[3*i +: 3];
    end
    case (w_cur_colour)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: w_cyc_colour = w_cur_colour + 3'd1;
      default:                      w_cyc_colour = 3'd1;
    endcase
  end

  // Cursor move with wrap; priority up > down > left > right
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (w_edge[B_UP]) begin
      w_row_nxt = (r_row == '0) ? CW'(GRID_N - 1) : r_row - CW'(1);
    end else if (w_edge[B_DOWN]) begin
      w_row_nxt = (r_row == CW'(GRID_N - 1)) ? '0 : r_row + CW'(1);
    end else if (w_edge[B_LEFT]) begin
      w_col_nxt = (r_col == '0) ? CW'(GRID_N - 1) : r_col - CW'(1);
    end else if (w_edge[B_RIGHT]) begin
      w_col_nxt = (r_col == CW'(GRID_N - 1)) ? '0 : r_col + CW'(1);
    end
  end

`ifdef GRID_CURSOR_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic          w_move;

  assign w_move = |w_edge[B_UP:B_RIGHT];

  // Free-running blink timer, restarted at the lit phase on any move
  always_ff @(posedge clk) begin
    if (rst || w_move) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BW'(1);
    end
  end

  assign w_blink_phase = r_blink_phase;
`else
  // Steady lit cursor; BLINK_CYCLES stays referenced so both builds share one parameter list
  assign w_blink_phase = 1'b0 & (BLINK_CYCLES != 0);
`endif

  assign w_cursor_border = w_blink_phase ? 3'b000 : 3'b111;

  // Pixel classification against every square (10-bit, non-wrapping)
  always_comb begin
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] ox;
    logic [9:0] oy;
    w_isSet  = 1'b0;
    w_colour = 3'b000;
    px = 10'(isX);
    py = 10'(isY);
    ox = '0;
    oy = '0;
    for (int r = 0; r < int'(GRID_N); r++) begin
      for (int c = 0; c < int'(GRID_N); c++) begin
        ox = 10'(X_pos) + 10'(c * int'(PITCH));
        oy = 10'(Y_pos) + 10'(r * int'(PITCH));
        if ((px > ox) && (px < ox + 10'(SQ_LEN)) &&
            (py > oy) && (py < oy + 10'(SQ_LEN))) begin
          w_isSet = 1'b1;
          if ((px < ox + 10'(BORDER)) || (px > ox + 10'(SQ_LEN - BORDER)) ||
              (py < oy + 10'(BORDER)) || (py > oy + 10'(SQ_LEN - BORDER))) begin
            w_colour = ((CW'(r) == r_row) && (CW'(c) == r_col)) ? w_cursor_border : 3'b000;
          end else begin
            w_colour = r_state[3*(r*int'(GRID_N)+c) +: 3];
          end
        end
      end
    end
  end

  // Grid state, cursor, button history and pixel output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= {NSQ{INIT_COLOUR}};
      r_row    <= '0;
      r_col    <= '0;
      r_btn_q  <= '0;
      r_arm    <= 1'b0;
      r_isSet  <= 1'b0;
      r_colour <= 3'b000;
    end else begin
      r_btn_q  <= w_btn;
      r_arm    <= 1'b1;
      r_isSet  <= w_isSet;
      r_colour <= w_colour;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      // Cycle targets the pre-move cursor square
      for (int i = 0; i < int'(NSQ); i++) begin
        if (w_edge[B_CYC] && (w_cur_idx == 32'(i))) r_state[3*i +: 3] <= w_cyc_colour;
      end
    end
  end

  assign isSet      = r_isSet;
  assign colour     = r_colour;
  assign cursor_row = r_row;
  assign cursor_col = r_col;
  assign state_flat = r_state;

endmodule

// File: doc/face_grid_editor.md
FACE_GRID_EDITOR -- requirements
Module: face_grid_editor

Interface
REQ-001 SHALL have parameter GRID_N, default 3, meaning squares per row and per column.
REQ-002 SHALL have parameter SQ_LEN, default 26, meaning square edge length in pixels.
REQ-003 SHALL have parameter BORDER, default 3, meaning border thickness in pixels.
REQ-004 SHALL have parameter GAP, default 2, meaning spacing between adjacent squares; PITCH = SQ_LEN + GAP.
REQ-005 SHALL have parameter INIT_COLOUR, default 3'b001, meaning the reset colour of every square.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports isX and isY, inputs, 9 and 8 bits, the current pixel coordinate.
REQ-009 SHALL have ports X_pos and Y_pos, inputs, 9 and 8 bits, the grid top-left origin.
REQ-010 SHALL have ports btn_up, btn_down, btn_left, btn_right and btn_cycle, inputs, 1 bit each, level, synchronous to clk.
REQ-011 SHALL have port isSet, output, 1, meaning the pixel lies inside any square.
REQ-012 SHALL have port colour, output, 3, the pixel colour.
REQ-013 SHALL have ports cursor_row and cursor_col, outputs, $clog2(GRID_N) bits each, the cursor position.
REQ-014 SHALL have port state_flat, output, 3*GRID_N*GRID_N bits, the square colours; square (r,c) occupies bits [3*(r*GRID_N+c) +: 3].

Function
REQ-015 SHALL register every button and act only on a 0->1 transition, giving one action per press regardless of hold length.
REQ-016 On a btn_cycle edge, the square under the cursor SHALL advance 1->2->3->4->5->6->1; a stored 0 or 7 SHALL go to 1.
REQ-017 Move edges SHALL step the cursor by one square, wrapping at both ends: up from row 0 goes to GRID_N-1, and right from column GRID_N-1 goes to 0.
REQ-018 If several move edges occur in one cycle, only the highest-priority move SHALL apply, in the order up > down > left > right.
REQ-019 A cycle edge coincident with a move edge SHALL modify the square at the pre-move cursor position, and the move SHALL take effect in the same cycle.
REQ-020 Square (r,c) origin SHALL be ox = X_pos + c*PITCH and oy = Y_pos + r*PITCH, with all arithmetic in 10 bits and no wrap.
REQ-021 A pixel SHALL be inside square (r,c) when ox < isX < ox+SQ_LEN and oy < isY < oy+SQ_LEN (strict inequalities).
REQ-022 An inside pixel SHALL be border when isX < ox+BORDER, isX > ox+SQ_LEN-BORDER, isY < oy+BORDER or isY > oy+SQ_LEN-BORDER.
REQ-023 Border colour SHALL be 3'b111 on the cursor square (subject to REQ-031) and 3'b000 on all other squares.
REQ-024 An inside non-border pixel SHALL output the stored colour of its square.
REQ-025 Pixels in gaps or outside the grid SHALL give isSet=0 and colour=3'b000.
REQ-026 isSet and colour SHALL be registered, with exactly one clk of latency from isX/isY/X_pos/Y_pos.
REQ-027 cursor_row, cursor_col and state_flat SHALL be registered and reflect an edge on the clk after the edge is detected.

Reset
REQ-028 While rst=1 on a clk edge: every square SHALL be set to INIT_COLOUR, the cursor to (0,0), isSet to 0, colour to 3'b000, button history to 0 and the blink counter to 0.
REQ-029 A reset asserted mid-operation SHALL discard pending edges; a button held across reset release SHALL NOT trigger an action until it is released and pressed again.

Configuration
REQ-030 SHALL have macro GRID_CURSOR_BLINK_EN and parameter BLINK_CYCLES, default 12500000.
REQ-031 With GRID_CURSOR_BLINK_EN defined, a free-running counter SHALL toggle a blink phase every BLINK_CYCLES clocks.
- Phase 0: the cursor border uses 3'b111.
- Phase 1: the cursor border uses 3'b000.
- The counter and phase SHALL restart at phase 0 on any cursor move.
REQ-032 Without GRID_CURSOR_BLINK_EN, the cursor border SHALL be steady 3'b111, with no counter logic.

Verification
REQ-033 rst high for 2 clks -> state_flat = nine copies of 3'b001, cursor (0,0), isSet=0, colour=000.
REQ-034 btn_cycle pulsed 6 times at (0,0) -> square 0 goes 2,3,4,5,6,1; btn_cycle held 100 clks -> exactly one advance.
REQ-035 btn_left once from (0,0) -> cursor_col=2; btn_up then -> cursor_row=2; btn_up and btn_right in the same clk -> only the row changes.
REQ-036 X_pos=10, Y_pos=10, pixel (50,20) -> after 1 clk isSet=1 and colour = square (0,1) colour; pixel (37,20) -> isSet=0; pixel (39,20) -> border 000.
REQ-037 Cursor at (0,0), pixel (11,20) -> colour=111; with GRID_CURSOR_BLINK_EN and BLINK_CYCLES=4 -> colour alternates 111/000 every 4 clks.
REQ-038 btn_cycle and btn_down in the same clk at (1,1) -> square (1,1) advances and the cursor becomes (2,1).
